bluetooth_rsp: RTL and testbench

UART-style serial receiver for the Bluetooth module's response/status line. It is the receive-side counterpart of bluetooth_cmd: 8N1 framing, LSB first, idle-high line, same CLKS_PER_BIT bit timing. It deserialises each frame into a parallel byte with a one-cycle valid strobe, and flags framing errors, for the command/response controller.

---
 rtl/bluetooth_rsp.sv | 143 ++++++++++++++
 tb/tb_bluetooth_rsp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_rsp.sv
// 8N1 serial receiver for the Bluetooth response line; byte out ~9.5 bit times after the start edge.
// No backpressure: out_rx_valid / out_rx_frame_err are single-cycle strobes the consumer must take.
module bluetooth_rsp #(
    parameter int N_BITS       = 8,
    parameter int CLKS_PER_BIT = 55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_rx_serial,
    output logic [N_BITS-1:0] out_rx_data,
    output logic              out_rx_valid,
    output logic              out_rx_frame_err,
    output logic              out_rx_active
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(N_BITS) + 1;

    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_START_BIT,
        RX_DATA_BITS,
        RX_STOP_BIT,
        CLEANUP,
        WAIT_IDLE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [BW-1:0]     bit_index, bit_index_nxt;
    logic [N_BITS-1:0] shift, shift_nxt;
    logic [N_BITS-1:0] data_nxt;
    logic              valid_nxt, err_nxt, active_nxt;
    logic              rx_meta, rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= in_rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            bit_index        <= '0;
            shift            <= '0;
            out_rx_data      <= '0;
            out_rx_valid     <= 1'b0;
            out_rx_frame_err <= 1'b0;
            out_rx_active    <= 1'b0;
        end else begin
            state            <= state_nxt;
            count            <= count_nxt;
            bit_index        <= bit_index_nxt;
            shift            <= shift_nxt;
            out_rx_data      <= data_nxt;
            out_rx_valid     <= valid_nxt;
            out_rx_frame_err <= err_nxt;
            out_rx_active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        bit_index_nxt = bit_index;
        shift_nxt     = shift;
        data_nxt      = out_rx_data;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                count_nxt     = '0;
                bit_index_nxt = '0;
                if (!rx_s) state_nxt = RX_START_BIT;
            end
            RX_START_BIT: begin
                if (count == HALF_CNT) begin
                    count_nxt = '0;
                    // Line back high by mid start bit: a glitch, not a frame.
                    state_nxt = rx_s ? IDLE : RX_DATA_BITS;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RX_DATA_BITS: begin
                if (count == LAST_CNT) begin
                    count_nxt = '0;
                    for (int i = 0; i < N_BITS; i++) begin
                        if (bit_index == BW'(i)) shift_nxt[i] = rx_s;
                    end
                    if (bit_index < LAST_IDX) begin
                        bit_index_nxt = bit_index + 1'b1;
                    end else begin
                        bit_index_nxt = '0;
                        state_nxt     = RX_STOP_BIT;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RX_STOP_BIT: begin
                if (count == LAST_CNT) begin
                    count_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = CLEANUP;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            CLEANUP: state_nxt = IDLE;
            // A held-low (break) line must return high before another start is accepted.
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default: begin
                state_nxt     = IDLE;
                count_nxt     = '0;
                bit_index_nxt = '0;
            end
        endcase

        active_nxt = (state_nxt == RX_START_BIT) || (state_nxt == RX_DATA_BITS) ||
                     (state_nxt == RX_STOP_BIT);
    end

endmodule

// File: tb/tb_bluetooth_rsp.sv
// Directed bench for bluetooth_rsp: default 55 clk/bit instance plus a 16 clk/bit instance.
module tb_bluetooth_rsp;

    logic       clk;
    logic       rst;
    logic       rx55, rx16;
    logic [7:0] d55, d16;
    logic       v55, e55, a55;
    logic       v16, e16, a16;

    int n_assert = 0;
    int n_fail   = 0;

    int  vcnt55 = 0, ecnt55 = 0, vcnt16 = 0, ecnt16 = 0;
    int  both_cnt = 0, long_cnt = 0, act_cycles = 0;
    logic pv55 = 1'b0, pv16 = 1'b0;
    logic [7:0] q55[$];
    time t_fall, tv55, tv16;

    bluetooth_rsp dut55 (
        .clk(clk), .rst(rst), .in_rx_serial(rx55),
        .out_rx_data(d55), .out_rx_valid(v55),
        .out_rx_frame_err(e55), .out_rx_active(a55)
    );

    bluetooth_rsp #(.N_BITS(8), .CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .in_rx_serial(rx16),
        .out_rx_data(d16), .out_rx_valid(v16),
        .out_rx_frame_err(e16), .out_rx_active(a16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (v55) begin
            vcnt55++;
            q55.push_back(d55);
            tv55 = $time;
        end
        if (e55) ecnt55++;
        if (v16) begin
            vcnt16++;
            tv16 = $time;
        end
        if (e16) ecnt16++;
        if ((v55 && e55) || (v16 && e16)) both_cnt++;
        if ((v55 && pv55) || (v16 && pv16)) long_cnt++;
        if (a55) act_cycles++;
        pv55 = v55;
        pv16 = v16;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_next(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'h00;
        if (q55.size() > 0) got = q55.pop_front();
        else got = ~exp;
        check(tag, 32'(got), 32'(exp));
    endtask

    // Drives the first nbits of {stop, data LSB first, start}, one bit period each.
    task automatic send_frame(input bit sel16, input logic [7:0] b, input bit stop_ok, input int nbits);
        logic [9:0] fr;
        int         cpb;
        fr  = {stop_ok, b, 1'b0};
        cpb = sel16 ? 16 : 55;
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            if (i == 0) t_fall = $time;
            if (sel16) rx16 = fr[i];
            else       rx55 = fr[i];
            repeat (cpb - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    int base_v, base_e;

    initial begin
        rst  = 1'b1;
        rx55 = 1'b1;
        rx16 = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset_data", 32'(d55), 32'h00);
        check("reset_valid", 32'(v55), 32'h0);
        check("reset_err", 32'(e55), 32'h0);
        check("reset_active", 32'(a55), 32'h0);
        check("reset_data16", 32'(d16), 32'h00);
        @(posedge clk);
        rst = 1'b0;
        idle(20);

        // Single frame 0xA5
        base_v = vcnt55; base_e = ecnt55; act_cycles = 0;
        send_frame(0, 8'hA5, 1, 10);
        idle(110);
        @(negedge clk);
        check("a5_count", 32'(vcnt55 - base_v), 32'd1);
        check_next("a5_data", 8'hA5);
        check("a5_out_data", 32'(d55), 32'hA5);
        check("a5_no_err", 32'(ecnt55 - base_e), 32'd0);
        check_range("a5_latency", int'((tv55 - t_fall) / 10), 522, 526);
        check_range("a5_active_len", act_cycles, 520, 526);

        // Back-to-back frames, no idle gap
        base_v = vcnt55;
        send_frame(0, 8'h00, 1, 10);
        send_frame(0, 8'hFF, 1, 10);
        send_frame(0, 8'h3C, 1, 10);
        idle(110);
        @(negedge clk);
        check("b2b_count", 32'(vcnt55 - base_v), 32'd3);
        check_next("b2b_0", 8'h00);
        check_next("b2b_1", 8'hFF);
        check_next("b2b_2", 8'h3C);
        check("b2b_no_err", 32'(ecnt55 - base_e), 32'd0);

        // Stop bit low then line held low three bit times
        base_v = vcnt55;
        send_frame(0, 8'h5A, 0, 10);
        idle(3 * 55);
        rx55 = 1'b1;
        idle(110);
        @(negedge clk);
        check("ferr_count", 32'(ecnt55 - base_e), 32'd1);
        check("ferr_no_valid", 32'(vcnt55 - base_v), 32'd0);
        check("ferr_data_kept", 32'(d55), 32'h3C);
        send_frame(0, 8'h81, 1, 10);
        idle(110);
        @(negedge clk);
        check("after_err_count", 32'(vcnt55 - base_v), 32'd1);
        check_next("after_err_data", 8'h81);
        check("after_err_errs", 32'(ecnt55 - base_e), 32'd1);

        // Glitch: 10 cycles low
        base_v = vcnt55; base_e = ecnt55;
        @(posedge clk);
        rx55 = 1'b0;
        idle(8);
        @(negedge clk);
        check("glitch_active_hi", 32'(a55), 32'h1);
        idle(2);
        rx55 = 1'b1;
        idle(60);
        @(negedge clk);
        check("glitch_active_lo", 32'(a55), 32'h0);
        check("glitch_no_valid", 32'(vcnt55 - base_v), 32'd0);
        check("glitch_no_err", 32'(ecnt55 - base_e), 32'd0);
        send_frame(0, 8'h42, 1, 10);
        idle(110);
        @(negedge clk);
        check("post_glitch_count", 32'(vcnt55 - base_v), 32'd1);
        check_next("post_glitch_data", 8'h42);

        // Reset during data bit 4 of frame 0xF0 (tail bits all high)
        base_v = vcnt55; base_e = ecnt55;
        send_frame(0, 8'hF0, 1, 5);
        @(posedge clk);
        rx55 = 1'b1;
        idle(20);
        @(negedge clk);
        check("mid_active", 32'(a55), 32'h1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("rst_data", 32'(d55), 32'h00);
        check("rst_valid", 32'(v55), 32'h0);
        check("rst_err", 32'(e55), 32'h0);
        check("rst_active", 32'(a55), 32'h0);
        idle(3);
        rst = 1'b0;
        idle(4 * 55);
        @(negedge clk);
        check("rst_tail_no_valid", 32'(vcnt55 - base_v), 32'd0);
        check("rst_tail_no_err", 32'(ecnt55 - base_e), 32'd0);
        send_frame(0, 8'hC3, 1, 10);
        idle(110);
        @(negedge clk);
        check("post_rst_count", 32'(vcnt55 - base_v), 32'd1);
        check_next("post_rst_data", 8'hC3);

        // 16 clk/bit instance, frame 0x96
        base_v = vcnt16;
        send_frame(1, 8'h96, 1, 10);
        idle(40);
        @(negedge clk);
        check("cpb16_count", 32'(vcnt16 - base_v), 32'd1);
        check("cpb16_data", 32'(d16), 32'h96);
        check("cpb16_no_err", 32'(ecnt16), 32'd0);
        check_range("cpb16_latency", int'((tv16 - t_fall) / 10), 151, 155);

        check("pulses_exclusive", 32'(both_cnt), 32'd0);
        check("pulses_single_cycle", 32'(long_cnt), 32'd0);
        check("no_extra_frames", 32'(q55.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
